// File: rtl/vga_plot_ctrl.sv
// Pixel-write sequencer for the VGA framebuffer adapter: turns CPU plot levels
// into single-cycle strobes and arbitrates them against a full-screen clear sweep.
module vga_plot_ctrl #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int XW     = 8,
  parameter int YW     = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    cpu_x,
  input  logic [7:0]    cpu_y,
  input  logic [2:0]    cpu_colour,
  input  logic          cpu_plot,
  input  logic          clear_req,
  input  logic [2:0]    clear_colour,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [2:0]    colour,
  output logic          plot,
  output logic          busy,
  output logic          clear_done,
  output logic          overrun,
  output logic          dropped
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_t          state, state_nxt;
  logic            cpu_plot_p1;
  logic            pend, pend_nxt;
  logic [XW-1:0]   pend_x, pend_x_nxt;
  logic [YW-1:0]   pend_y, pend_y_nxt;
  logic [2:0]      pend_colour, pend_colour_nxt;
  logic [XW-1:0]   x_nxt;
  logic [YW-1:0]   y_nxt;
  logic [2:0]      colour_nxt;
  logic            plot_nxt, busy_nxt, clear_done_nxt, overrun_nxt, dropped_nxt;
  logic            req, req_ok;

  function automatic logic in_range(input logic [7:0] px, input logic [7:0] py);
    return (32'(px) < WIDTH) && (32'(py) < HEIGHT);
  endfunction

  assign req    = cpu_plot & ~cpu_plot_p1;
  assign req_ok = req & in_range(cpu_x, cpu_y);

  always_comb begin
    state_nxt       = state;
    x_nxt           = x;
    y_nxt           = y;
    colour_nxt      = colour;
    plot_nxt        = 1'b0;
    clear_done_nxt  = 1'b0;
    pend_nxt        = pend;
    pend_x_nxt      = pend_x;
    pend_y_nxt      = pend_y;
    pend_colour_nxt = pend_colour;
    overrun_nxt     = overrun;
    dropped_nxt     = dropped | (req & ~req_ok);

    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt  = CLEAR;
          x_nxt      = '0;
          y_nxt      = '0;
          colour_nxt = clear_colour;
          plot_nxt   = 1'b1;
          if (req_ok) begin
            pend_nxt        = 1'b1;
            pend_x_nxt      = cpu_x[XW-1:0];
            pend_y_nxt      = cpu_y[YW-1:0];
            pend_colour_nxt = cpu_colour;
            overrun_nxt     = overrun | pend;
          end
        end else if (pend) begin
          // Drain the slot; a request arriving now refills it behind the drain.
          x_nxt      = pend_x;
          y_nxt      = pend_y;
          colour_nxt = pend_colour;
          plot_nxt   = 1'b1;
          pend_nxt   = req_ok;
          if (req_ok) begin
            pend_x_nxt      = cpu_x[XW-1:0];
            pend_y_nxt      = cpu_y[YW-1:0];
            pend_colour_nxt = cpu_colour;
          end
        end else if (req_ok) begin
          x_nxt      = cpu_x[XW-1:0];
          y_nxt      = cpu_y[YW-1:0];
          colour_nxt = cpu_colour;
          plot_nxt   = 1'b1;
        end
      end
      CLEAR: begin
        // x/y double as the sweep counters; colour holds the latched fill.
        if (x == X_LAST && y == Y_LAST) begin
          state_nxt      = IDLE;
          clear_done_nxt = 1'b1;
        end else begin
          plot_nxt = 1'b1;
          if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = y + 1'b1;
          end else begin
            x_nxt = x + 1'b1;
          end
        end
        if (req_ok) begin
          pend_nxt        = 1'b1;
          pend_x_nxt      = cpu_x[XW-1:0];
          pend_y_nxt      = cpu_y[YW-1:0];
          pend_colour_nxt = cpu_colour;
          overrun_nxt     = overrun | pend;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == CLEAR) | pend_nxt;
  end

  // The edge register follows cpu_plot even during reset, so a level held
  // high across reset release is not mistaken for a new request.
  always_ff @(posedge clk) begin
    cpu_plot_p1 <= cpu_plot;
    pend_x      <= pend_x_nxt;
    pend_y      <= pend_y_nxt;
    pend_colour <= pend_colour_nxt;
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      overrun    <= 1'b0;
      dropped    <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      colour     <= colour_nxt;
      plot       <= plot_nxt;
      busy       <= busy_nxt;
      clear_done <= clear_done_nxt;
      overrun    <= overrun_nxt;
      dropped    <= dropped_nxt;
      pend       <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_vga_plot_ctrl.sv
// Directed bench for vga_plot_ctrl: reset, single plots, range drops,
// full clear sweeps, clear/plot collisions with overrun, and reset abort.
module tb_vga_plot_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_x, cpu_y;
  logic [2:0] cpu_colour;
  logic       cpu_plot;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, clear_done, overrun, dropped;

  int n_pass = 0;
  int n_chk  = 0;

  vga_plot_ctrl #(.WIDTH(160), .HEIGHT(120), .XW(8), .YW(7)) dut (
    .clk(clk), .reset(reset),
    .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_colour(cpu_colour), .cpu_plot(cpu_plot),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .clear_done(clear_done), .overrun(overrun), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks the 19200 sweep cycles starting at pixel (0,0); mode 1 pulses an
  // ignored clear_req mid-sweep, mode 2 issues two CPU edges (1,1) then (2,2).
  task automatic sweep(input logic [2:0] col, input int mode);
    int bad_xy = 0, bad_plot = 0, bad_col = 0, bad_busy = 0, dones = 0;
    for (int i = 0; i < 19200; i++) begin
      if (x != 8'(i % 160) || y != 7'(i / 160)) bad_xy++;
      if (!plot) bad_plot++;
      if (colour != col) bad_col++;
      if (!busy) bad_busy++;
      if (clear_done) dones++;
      if (i == 0) begin
        check("sweep_first_x", x, 0);
        check("sweep_first_y", y, 0);
      end
      if (i == 160) begin
        check("sweep_p160_x", x, 0);
        check("sweep_p160_y", y, 1);
      end
      if (i == 19199) begin
        check("sweep_last_x", x, 159);
        check("sweep_last_y", y, 119);
      end
      if (mode == 1) begin
        if (i == 1000) begin clear_req = 1'b1; clear_colour = 3'd7; end
        if (i == 1001) clear_req = 1'b0;
      end
      if (mode == 2) begin
        if (i == 100) begin cpu_x = 8'd1; cpu_y = 8'd1; cpu_colour = 3'd3; cpu_plot = 1'b1; end
        if (i == 102) cpu_plot = 1'b0;
        if (i == 103) check("overrun_after_first", overrun, 0);
        if (i == 104) begin cpu_x = 8'd2; cpu_y = 8'd2; cpu_colour = 3'd4; cpu_plot = 1'b1; end
        if (i == 106) cpu_plot = 1'b0;
        if (i == 150) check("overrun_after_second", overrun, 1);
      end
      tick();
    end
    check("sweep_xy_errors", bad_xy, 0);
    check("sweep_plot_gaps", bad_plot, 0);
    check("sweep_colour_errors", bad_col, 0);
    check("sweep_busy_gaps", bad_busy, 0);
    check("sweep_early_done", dones, 0);
    check("done_pulse", clear_done, 1);
    check("done_plot", plot, 0);
  endtask

  initial begin
    reset = 1'b1; cpu_x = '0; cpu_y = '0; cpu_colour = '0;
    cpu_plot = 1'b1; clear_req = 1'b0; clear_colour = '0;
    tick(); tick();
    check("rst_plot", plot, 0);
    check("rst_xyc", {x, y, colour}, 0);
    check("rst_flags", {busy, clear_done, overrun, dropped}, 0);
    reset = 1'b0;
    tick();
    check("held_plot_0", plot, 0);
    tick();
    check("held_plot_1", plot, 0);

    // Single plot, then level held high
    cpu_plot = 1'b0; cpu_x = 8'd10; cpu_y = 8'd20; cpu_colour = 3'b101;
    tick();
    cpu_plot = 1'b1;
    tick();
    check("single_plot", plot, 1);
    check("single_x", x, 10);
    check("single_y", y, 20);
    check("single_colour", colour, 5);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("held_no_replot", plot, 0);
    end
    cpu_plot = 1'b0;
    tick();

    // Out of range in x, then in y, then boundary pixel
    cpu_x = 8'd160; cpu_y = 8'd5; cpu_plot = 1'b1;
    tick();
    check("oor_x_plot", plot, 0);
    check("oor_x_dropped", dropped, 1);
    cpu_plot = 1'b0;
    tick();
    cpu_x = 8'd0; cpu_y = 8'd120; cpu_plot = 1'b1;
    tick();
    check("oor_y_plot", plot, 0);
    cpu_plot = 1'b0;
    tick();
    check("dropped_sticky", dropped, 1);
    cpu_x = 8'd159; cpu_y = 8'd119; cpu_colour = 3'd3; cpu_plot = 1'b1;
    tick();
    check("edge_plot", plot, 1);
    check("edge_xy", {x, y}, {8'd159, 7'd119});
    check("edge_colour", colour, 3);
    cpu_plot = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Full clear with an ignored clear_req mid-sweep
    clear_colour = 3'b010; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    sweep(3'b010, 1);
    check("done_busy", busy, 0);
    tick();
    check("done_single", clear_done, 0);
    check("post_clear_plot", plot, 0);

    // Collision: clear and valid edge together
    clear_colour = 3'd1; clear_req = 1'b1;
    cpu_x = 8'd7; cpu_y = 8'd9; cpu_colour = 3'd6; cpu_plot = 1'b1;
    tick();
    clear_req = 1'b0; cpu_plot = 1'b0;
    sweep(3'd1, 0);
    check("pend_busy_at_done", busy, 1);
    tick();
    check("pend_plot", plot, 1);
    check("pend_xy", {x, y}, {8'd7, 7'd9});
    check("pend_colour", colour, 6);
    check("pend_busy_after", busy, 0);
    check("no_overrun_yet", overrun, 0);
    tick();

    // Two edges during a clear: latest wins, overrun set
    clear_colour = 3'd4; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    sweep(3'd4, 2);
    tick();
    check("overrun_plot", plot, 1);
    check("overrun_xy", {x, y}, {8'd2, 7'd2});
    check("overrun_colour", colour, 4);
    check("overrun_sticky", overrun, 1);
    tick();
    check("only_one_issued", plot, 0);

    // Abort at sweep pixel 500
    clear_colour = 3'd5; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 500; k++) tick();
    check("abort_pixel_x", x, 500 % 160);
    check("abort_pixel_y", y, 500 / 160);
    reset = 1'b1;
    tick();
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    begin
      int done_seen = 0, plot_seen = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (clear_done) done_seen++;
        if (plot) plot_seen++;
      end
      check("abort_no_done", done_seen, 0);
      check("abort_no_plot", plot_seen, 0);
    end
    check("abort_flags_cleared", {overrun, dropped}, 0);
    clear_colour = 3'd6; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("restart_plot", plot, 1);
    check("restart_xy", {x, y}, 0);
    check("restart_colour", colour, 6);
    tick();
    check("restart_second_x", x, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
